// File: rtl/win_addr_gen.sv
// 2x2 window address generator: window position counters, tap read addressing, result write pointer.
// Optional protocol checker for the controller strobes is built when WIN_PROTO_CHK_EN is defined.
module win_addr_gen #(
   parameter int IMG_W    = 16,
   parameter int IMG_H    = 16,
   parameter int ADDR_W   = 9,
   parameter int IN_BASE  = 0,
   parameter int OUT_BASE = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pixel_cnt_en,
   input  logic              addr_cal_en,
   input  logic              read,
   input  logic              write,
   input  logic [3:0]        load,
   output logic [3:0]        col,
   output logic [3:0]        row,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [1:0]        tap_idx,
   output logic              frame_done,
   output logic              err
);

   localparam int AW1 = ADDR_W + 1;

   // State encoding equals the tap index it expects (TL=3 .. BR=0).
   typedef enum logic [1:0] {
      EXPECT_TL = 2'd3,
      EXPECT_TR = 2'd2,
      EXPECT_BL = 2'd1,
      EXPECT_BR = 2'd0
   } tap_state_t;

   tap_state_t          state_reg;
   logic [3:0]          col_reg;
   logic [3:0]          row_reg;
   logic [ADDR_W-1:0]   wr_ptr_reg;
   logic                frame_done_reg;

   logic                rd_act;
   logic                wr_act;
   logic [1:0]          tap_enc;
   logic [AW1-1:0]      base_pos;
   logic [AW1-1:0]      wr_addr;
   logic [AW1-1:0]      tap_addr [4];

   assign wr_act = write & addr_cal_en & ~rst;
   assign rd_act = read & addr_cal_en & ~write & ~rst;

   // Lowest set bit of load wins when more than one is set.
   always_comb begin
      tap_enc = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (load[i]) tap_enc = 2'(i);
      end
   end

   assign base_pos = AW1'(IN_BASE) + AW1'(row_reg) * AW1'(IMG_W) + AW1'(col_reg);
   assign wr_addr  = AW1'(OUT_BASE) + AW1'(wr_ptr_reg);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_tap
         // Taps 3/2 sit on the top line, taps 2/0 are the right-hand column.
         localparam int OFF = (((gi >> 1) == 0) ? IMG_W : 0) + (((gi & 1) == 0) ? 1 : 0);
         assign tap_addr[gi] = base_pos + AW1'(OFF);
      end
   endgenerate

   always_comb begin
      mem_addr = '0;
      tap_idx  = 2'd0;
      if (wr_act) begin
         mem_addr = wr_addr[ADDR_W-1:0];
      end else if (rd_act) begin
         mem_addr = tap_addr[tap_enc][ADDR_W-1:0];
         tap_idx  = tap_enc;
      end
   end

   assign mem_re     = rd_act;
   assign mem_we     = wr_act;
   assign col        = col_reg;
   assign row        = row_reg;
   assign frame_done = frame_done_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= EXPECT_TL;
         col_reg        <= '0;
         row_reg        <= '0;
         wr_ptr_reg     <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         frame_done_reg <= 1'b0;
         if (wr_act) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pixel_cnt_en) begin
            state_reg <= EXPECT_TL;
            if (col_reg < 4'(IMG_W - 2)) begin
               col_reg <= col_reg + 4'd1;
            end else begin
               col_reg <= '0;
               if (row_reg < 4'(IMG_H - 2)) begin
                  row_reg <= row_reg + 4'd1;
               end else begin
                  // Frame end clears the result pointer even over a coincident write.
                  row_reg        <= '0;
                  wr_ptr_reg     <= '0;
                  frame_done_reg <= 1'b1;
               end
            end
         end else if (rd_act) begin
            case (state_reg)
               EXPECT_TL: state_reg <= EXPECT_TR;
               EXPECT_TR: state_reg <= EXPECT_BL;
               EXPECT_BL: state_reg <= EXPECT_BR;
               default:   state_reg <= EXPECT_TL;
            endcase
         end
      end
   end

`ifdef WIN_PROTO_CHK_EN
   logic       err_reg;
   logic [3:0] exp_load;
   logic       err_hit;

   assign exp_load = 4'b0001 << state_reg;
   assign err_hit  = (read & (load != exp_load))
                   | ((read | write) & ~addr_cal_en)
                   | (read & write)
                   | (write & (state_reg != EXPECT_TL));

   always_ff @(posedge clk) begin
      if (rst)          err_reg <= 1'b0;
      else if (err_hit) err_reg <= 1'b1;
   end

   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_win_addr_gen.sv
// Directed bench for win_addr_gen: tap addressing, scan wrap, frame end, writes, reset behaviour.
module tb_win_addr_gen;

   localparam int ADDR_W = 9;
`ifdef WIN_PROTO_CHK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              pixel_cnt_en = 1'b0;
   logic              addr_cal_en = 1'b0;
   logic              read = 1'b0;
   logic              write = 1'b0;
   logic [3:0]        load = 4'b0000;
   logic [3:0]        col;
   logic [3:0]        row;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [1:0]        tap_idx;
   logic              frame_done;
   logic              err;

   int n_cmp  = 0;
   int n_fail = 0;

   win_addr_gen #(.IMG_W(16), .IMG_H(16), .ADDR_W(ADDR_W), .IN_BASE(0), .OUT_BASE(256)) dut (
      .clk(clk), .rst(rst), .pixel_cnt_en(pixel_cnt_en), .addr_cal_en(addr_cal_en),
      .read(read), .write(write), .load(load), .col(col), .row(row), .mem_addr(mem_addr),
      .mem_re(mem_re), .mem_we(mem_we), .tap_idx(tap_idx), .frame_done(frame_done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int n);
      repeat (n) begin
         pixel_cnt_en = 1'b1;
         tick();
      end
      pixel_cnt_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; pixel_cnt_en = 1'b0; read = 1'b0; write = 1'b0; addr_cal_en = 1'b0; load = 4'b0000;
      tick(); tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (col !== 4'd0) begin n_fail++; $display("FAIL reset_col: got %0d want 0", col); end
      n_cmp++; if (row !== 4'd0) begin n_fail++; $display("FAIL reset_row: got %0d want 0", row); end
      n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
      n_cmp++; if ({mem_re, mem_we, mem_addr, tap_idx} !== '0) begin n_fail++;
         $display("FAIL reset_mem: got re=%b we=%b addr=%0d idx=%0d want all 0", mem_re, mem_we, mem_addr, tap_idx); end
      $display("reset: col=%0d row=%0d err=%b", col, row, err);
   endtask

   task automatic test_taps();
      logic [3:0] loads [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
      int         addrs [4] = '{0, 1, 16, 17};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         read = 1'b1; addr_cal_en = 1'b1; load = loads[i];
         #1;
         $display("read load=%b addr=%0d re=%b idx=%0d", load, mem_addr, mem_re, tap_idx);
         n_cmp++; if (mem_addr !== ADDR_W'(addrs[i])) begin n_fail++; $display("FAIL tap_addr[%0d]: got %0d want %0d", i, mem_addr, addrs[i]); end
         n_cmp++; if (mem_re !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL tap_re[%0d]: got re=%b we=%b want 1/0", i, mem_re, mem_we); end
         n_cmp++; if (tap_idx !== 2'(3 - i)) begin n_fail++; $display("FAIL tap_idx[%0d]: got %0d want %0d", i, tap_idx, 3 - i); end
         tick();
      end
      read = 1'b0; addr_cal_en = 1'b0; load = 4'b0000;
      #1;
      n_cmp++; if (mem_addr !== '0 || mem_re !== 1'b0) begin n_fail++; $display("FAIL idle: got addr=%0d re=%b want 0/0", mem_addr, mem_re); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL taps_err: got %b want 0", err); end
   endtask

   task automatic test_col_wrap();
      do_reset();
      pulse(14);
      n_cmp++; if (col !== 4'd14 || row !== 4'd0) begin n_fail++; $display("FAIL col14: got col=%0d row=%0d want 14/0", col, row); end
      pulse(1);
      n_cmp++; if (col !== 4'd0 || row !== 4'd1) begin n_fail++; $display("FAIL row1: got col=%0d row=%0d want 0/1", col, row); end
      read = 1'b1; addr_cal_en = 1'b1; load = 4'b1000;
      #1;
      $display("read load=%b addr=%0d at col=%0d row=%0d", load, mem_addr, col, row);
      n_cmp++; if (mem_addr !== 9'd16) begin n_fail++; $display("FAIL row1_tl: got %0d want 16", mem_addr); end
      tick();
      read = 1'b0; addr_cal_en = 1'b0; load = 4'b0000;
   endtask

   task automatic test_frame();
      do_reset();
      write = 1'b1; addr_cal_en = 1'b1;
      tick(); tick();
      write = 1'b0; addr_cal_en = 1'b0;
      pulse(224);
      n_cmp++; if (col !== 4'd14 || row !== 4'd14) begin n_fail++; $display("FAIL last_win: got col=%0d row=%0d want 14/14", col, row); end
      n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL early_done: got %b want 0", frame_done); end
      pulse(1);
      $display("frame end: col=%0d row=%0d frame_done=%b", col, row, frame_done);
      n_cmp++; if (col !== 4'd0 || row !== 4'd0) begin n_fail++; $display("FAIL frame_wrap: got col=%0d row=%0d want 0/0", col, row); end
      n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL frame_done: got %b want 1", frame_done); end
      tick();
      n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_done_pulse: got %b want 0", frame_done); end
      write = 1'b1; addr_cal_en = 1'b1;
      #1;
      $display("write addr=%0d after frame", mem_addr);
      n_cmp++; if (mem_addr !== 9'd256) begin n_fail++; $display("FAIL wr_ptr_clear: got %0d want 256", mem_addr); end
      tick();
      write = 1'b0; addr_cal_en = 1'b0;
   endtask

   task automatic test_writes();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         write = 1'b1; addr_cal_en = 1'b1;
         #1;
         $display("write addr=%0d we=%b re=%b", mem_addr, mem_we, mem_re);
         n_cmp++; if (mem_addr !== ADDR_W'(256 + i)) begin n_fail++; $display("FAIL wr_addr[%0d]: got %0d want %0d", i, mem_addr, 256 + i); end
         n_cmp++; if (mem_we !== 1'b1 || mem_re !== 1'b0) begin n_fail++; $display("FAIL wr_en[%0d]: got we=%b re=%b want 1/0", i, mem_we, mem_re); end
         tick();
      end
      write = 1'b0;
      addr_cal_en = 1'b1;
      #1;
      n_cmp++; if (mem_addr !== '0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_qual: got addr=%0d we=%b want 0/0", mem_addr, mem_we); end
      // Write beats read for address and enables.
      read = 1'b1; write = 1'b1; load = 4'b1000;
      #1;
      $display("read+write addr=%0d we=%b re=%b", mem_addr, mem_we, mem_re);
      n_cmp++; if (mem_addr !== 9'd259 || mem_we !== 1'b1 || mem_re !== 1'b0) begin n_fail++;
         $display("FAIL rw_conflict: got addr=%0d we=%b re=%b want 259/1/0", mem_addr, mem_we, mem_re); end
      tick();
      read = 1'b0; write = 1'b0; addr_cal_en = 1'b0; load = 4'b0000;
   endtask

   task automatic test_coincident();
      do_reset();
      pixel_cnt_en = 1'b1; read = 1'b1; addr_cal_en = 1'b1; load = 4'b1000;
      #1;
      $display("read+advance addr=%0d at col=%0d", mem_addr, col);
      n_cmp++; if (mem_addr !== 9'd0) begin n_fail++; $display("FAIL coinc_addr: got %0d want 0", mem_addr); end
      tick();
      pixel_cnt_en = 1'b0;
      #1;
      n_cmp++; if (col !== 4'd1) begin n_fail++; $display("FAIL coinc_col: got %0d want 1", col); end
      n_cmp++; if (mem_addr !== 9'd1) begin n_fail++; $display("FAIL coinc_next_tl: got %0d want 1", mem_addr); end
      tick();
      read = 1'b0; addr_cal_en = 1'b0; load = 4'b0000;
      #1;
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL coinc_err: got %b want 0", err); end
   endtask

   task automatic test_err();
      do_reset();
      read = 1'b1; addr_cal_en = 1'b1; load = 4'b0100;
      #1;
      n_cmp++; if (mem_re !== 1'b1 || mem_addr !== 9'd1) begin n_fail++; $display("FAIL bad_read_drive: got re=%b addr=%0d want 1/1", mem_re, mem_addr); end
      tick();
      read = 1'b0; addr_cal_en = 1'b0; load = 4'b0000;
      $display("out-of-order read: err=%b", err);
      n_cmp++; if (err !== CHK) begin n_fail++; $display("FAIL err_set: got %b want %b", err, CHK); end
      tick(); tick(); tick();
      n_cmp++; if (err !== CHK) begin n_fail++; $display("FAIL err_sticky: got %b want %b", err, CHK); end
      do_reset();
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      pulse(50);
      n_cmp++; if (col !== 4'd5 || row !== 4'd3) begin n_fail++; $display("FAIL mid_pos: got col=%0d row=%0d want 5/3", col, row); end
      read = 1'b1; addr_cal_en = 1'b1; load = 4'b1000;
      #1;
      n_cmp++; if (mem_addr !== 9'd53) begin n_fail++; $display("FAIL mid_tl: got %0d want 53", mem_addr); end
      tick();
      load = 4'b0100;
      #1;
      n_cmp++; if (mem_addr !== 9'd54) begin n_fail++; $display("FAIL mid_tr: got %0d want 54", mem_addr); end
      tick();
      read = 1'b0; addr_cal_en = 1'b0; load = 4'b0000;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      $display("mid reset: col=%0d row=%0d err=%b", col, row, err);
      n_cmp++; if (col !== 4'd0 || row !== 4'd0 || err !== 1'b0) begin n_fail++;
         $display("FAIL mid_reset: got col=%0d row=%0d err=%b want 0/0/0", col, row, err); end
      read = 1'b1; addr_cal_en = 1'b1; load = 4'b1000;
      #1;
      n_cmp++; if (mem_addr !== 9'd0 || tap_idx !== 2'd3) begin n_fail++; $display("FAIL post_reset_tl: got addr=%0d idx=%0d want 0/3", mem_addr, tap_idx); end
      tick();
      read = 1'b0; addr_cal_en = 1'b0; load = 4'b0000;
      #1;
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL post_reset_err: got %b want 0", err); end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_taps();
      test_col_wrap();
      test_frame();
      test_writes();
      test_coincident();
      test_err();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
